// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
//
// Serial-to-parallel UART receiver for 8N1-style frames (LSB first, no parity,
// one stop bit). The asynchronous rx line passes through a two-flop
// synchroniser. The start bit is validated at mid-bit, and each data bit and
// the stop bit are then sampled one bit period apart, so every sample falls
// near the centre of its bit. A completed word goes into a one-word holding
// register that is presented on a valid/ready port.
//
// The bit period matches the transmit serializer, so a tx->rx loopback with
// identical parameters round-trips every word.
//
// Parameters
//   CLOCKS_PER_PULSE  clock cycles per bit period (P), must be >= 4
//   BITS_PER_WORD     data bits per frame (N)
//
// Ports
//   clk        single clock, rising edge
//   rstn       asynchronous active-low reset
//   rx         asynchronous serial input, idles high
//   m_data     received word, stable while m_valid is high
//   m_valid    a word is available
//   m_ready    consumer accepts the word when m_valid && m_ready
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a completed word is dropped
//   busy       high whenever the FSM is not idle
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a falling edge on rx_s
//   ST_START | timing half a bit period to re-check the start bit
//   ST_DATA  | sampling N data bits, one per bit period
//   ST_STOP  | sampling the stop bit, then delivering the word or flagging
//   ST_BREAK | stop bit was low; wait for the line to return high
// -----------------------------------------------------------------------------
module uart_rx_deserializer #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int P  = CLOCKS_PER_PULSE;
  localparam int N  = BITS_PER_WORD;
  localparam int CW = $clog2(P);
  localparam int BW = $clog2(N + 1);

  // Compare values for the bit-period counter and the data-bit counter.
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(P / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]  shift_q, shift_d;

  logic rx_meta;
  logic rx_s;
  logic cnt_last;
  logic word_done;
  logic stop_bad;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle level, so leaving reset
  // can never look like a start bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, counters and shift register: state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign cnt_last = (clk_cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (clk_cnt_q == CNT_MID) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            // Still low at mid-bit: a genuine start bit. Data samples
            // follow at whole bit periods from here.
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end else begin
            // Line went back high before mid-bit: a glitch, ignore it.
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_last) begin
          clk_cnt_d = '0;
          // New sample enters at the MSB; after N samples the first bit
          // received (bit 0) has reached the LSB.
          shift_d   = N'({rx_s, shift_q} >> 1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_last) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            // Back to idle half a bit early so that a start bit following
            // this stop bit directly is caught.
            word_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      ST_BREAK: begin
        // A line held low must go high before a new start can be seen.
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Output holding register and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (word_done) begin
        if (!m_valid || m_ready) begin
          // Holding register empty, or the old word leaves this cycle.
          m_data  <= shift_q;
          m_valid <= 1'b1;
        end else begin
          // Consumer stalled: keep the old word and drop the new one.
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

  localparam int P = 16;
  localparam int N = 8;

  logic         clk;
  logic         rstn;
  logic         rx;
  logic         m_ready;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  uart_rx_deserializer #(
    .CLOCKS_PER_PULSE(P),
    .BITS_PER_WORD   (N)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every handshake and counts flag/busy cycles.
  int         rx_total     = 0;
  int         ferr_total   = 0;
  int         ovr_total    = 0;
  int         valid_cycles = 0;
  int         busy_cycles  = 0;
  logic [7:0] words  [0:63];
  int         hs_cyc [0:63];

  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && m_ready) begin
        words[rx_total % 64]  = m_data;
        hs_cyc[rx_total % 64] = cyc;
        rx_total = rx_total + 1;
      end
      if (m_valid)   valid_cycles = valid_cycles + 1;
      if (frame_err) ferr_total   = ferr_total + 1;
      if (overrun)   ovr_total    = ovr_total + 1;
      if (busy)      busy_cycles  = busy_cycles + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic hold_bit(input logic b);
    @(posedge clk);
    #1 rx = b;
    repeat (P - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    start_cyc = cyc;
    repeat (P - 1) @(posedge clk);
    for (int i = 0; i < N; i++) hold_bit(d[i]);
    hold_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_words;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, f0, o0, v0, b0;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[4] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 8'h81, 0};

    rstn    = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset m_valid",   int'(m_valid),   0);
    check("reset m_data",    int'(m_data),    0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun",   int'(overrun),   0);
    check("reset busy",      int'(busy),      0);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(4);

    // Table-driven single frames with an idle gap and m_ready high.
    for (int i = 0; i < 6; i++) begin
      w0 = rx_total; f0 = ferr_total; o0 = ovr_total; v0 = valid_cycles;
      send_frame(vecs[i].data, vecs[i].stop);
      idle(2 * P);
      check($sformatf("vec%0d words", i), rx_total - w0, vecs[i].exp_words);
      check($sformatf("vec%0d frame_err", i), ferr_total - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun", i), ovr_total - o0, 0);
      check($sformatf("vec%0d valid cycles", i), valid_cycles - v0, vecs[i].exp_words);
      if (vecs[i].exp_words == 1) begin
        check($sformatf("vec%0d m_data", i), int'(words[w0 % 64]), int'(vecs[i].exp_data));
        check_range($sformatf("vec%0d latency", i), hs_cyc[w0 % 64] - start_cyc, 153, 155);
      end
    end

    // Start-bit glitch: 4 cycles low.
    w0 = rx_total; f0 = ferr_total; b0 = busy_cycles;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    idle(2 * P);
    check("glitch words", rx_total - w0, 0);
    check("glitch frame_err", ferr_total - f0, 0);
    check_range("glitch busy cycles", busy_cycles - b0, 1, 9);
    check("glitch busy end", int'(busy), 0);

    // Framing error: stop low, then line held low for 3P more.
    w0 = rx_total; f0 = ferr_total;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) hold_bit(1'b0);
    @(negedge clk);
    check("break busy while low", int'(busy), 1);
    idle(2 * P);
    check("break frame_err pulses", ferr_total - f0, 1);
    check("break words", rx_total - w0, 0);
    check("break busy after rise", int'(busy), 0);
    send_frame(8'h3C, 1'b1);
    idle(2 * P);
    check("recover words", rx_total - w0, 1);
    check("recover m_data", int'(words[w0 % 64]), 8'h3C);

    // Overrun with m_ready held low.
    w0 = rx_total; o0 = ovr_total; f0 = ferr_total;
    @(posedge clk);
    #1 m_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(2 * P);
    send_frame(8'h22, 1'b1);
    idle(2 * P);
    @(negedge clk);
    #1;
    check("overrun pulses", ovr_total - o0, 1);
    check("overrun m_valid", int'(m_valid), 1);
    check("overrun m_data", int'(m_data), 8'h11);
    check("overrun words", rx_total - w0, 0);
    check("overrun frame_err", ferr_total - f0, 0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #2;
    check("overrun m_valid drop", int'(m_valid), 0);
    check("overrun handshake", rx_total - w0, 1);
    check("overrun handed word", int'(words[w0 % 64]), 8'h11);

    // Back-to-back stream, no idle gap.
    w0 = rx_total; f0 = ferr_total; o0 = ovr_total;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(2 * P);
    check("b2b words", rx_total - w0, 3);
    check("b2b word0", int'(words[w0 % 64]), 8'h00);
    check("b2b word1", int'(words[(w0 + 1) % 64]), 8'hFF);
    check("b2b word2", int'(words[(w0 + 2) % 64]), 8'h55);
    check("b2b frame_err", ferr_total - f0, 0);
    check("b2b overrun", ovr_total - o0, 0);

    // Reset midway through data bit 3 of 0x77.
    w0 = rx_total; f0 = ferr_total;
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    hold_bit(1'b1);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (P / 2 - 1) @(posedge clk);
    @(negedge clk);
    check("midframe busy", int'(busy), 1);
    @(posedge clk);
    #1 rstn = 1'b0;
    rx = 1'b1;
    #1;
    check("midreset m_data",    int'(m_data),    0);
    check("midreset m_valid",   int'(m_valid),   0);
    check("midreset frame_err", int'(frame_err), 0);
    check("midreset overrun",   int'(overrun),   0);
    check("midreset busy",      int'(busy),      0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2 * P);
    send_frame(8'h9E, 1'b1);
    idle(2 * P);
    check("postreset words", rx_total - w0, 1);
    check("postreset m_data", int'(words[w0 % 64]), 8'h9E);
    check("postreset frame_err", ferr_total - f0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
